// File: rtl/orbit_angle_bank.sv
// Bank of independent orbital angle accumulators with
// per-channel step, direction, pause, load and lap count.
module orbit_angle_bank #(
  parameter int NUM_CH    = 3,
  parameter int ANGLE_W   = 9,
  parameter int ANGLE_MAX = 359,
  parameter int STEP_W    = 4,
  parameter int LAP_W     = 8
) (
  input  logic                      clk1485,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         tick,
  input  logic [NUM_CH-1:0]         en,
  input  logic [NUM_CH-1:0]         dir,
  input  logic [NUM_CH*STEP_W-1:0]  step,
  input  logic                      freeze,
  input  logic [NUM_CH-1:0]         load,
  input  logic [NUM_CH*ANGLE_W-1:0] load_val,
  output logic [NUM_CH*ANGLE_W-1:0] angle,
  output logic [NUM_CH-1:0]         wrap,
  output logic [NUM_CH*LAP_W-1:0]   lap_cnt
);

  // Working width holds angle + step and the full modulus.
  localparam int CW = ((STEP_W > ANGLE_W) ? STEP_W : ANGLE_W) + 1;
  localparam logic [CW-1:0] MOD  = CW'(ANGLE_MAX + 1);
  localparam logic [CW-1:0] AMAX = CW'(ANGLE_MAX);
  localparam logic [LAP_W-1:0] ONE = LAP_W'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ANGLE_W-1:0] ang_q, ang_d;
    logic [LAP_W-1:0]   lap_q, lap_d;
    logic               wrap_q, wrap_d;
    logic [CW-1:0]      a, s, lv, sum;

    always_comb begin
      a = CW'(ang_q);
      s = CW'(step[i*STEP_W +: STEP_W]);
      if (s > MOD) s = MOD;
      lv = CW'(load_val[i*ANGLE_W +: ANGLE_W]);
      if (lv > AMAX) lv = AMAX;
      sum    = a + s;
      ang_d  = ang_q;
      lap_d  = lap_q;
      wrap_d = 1'b0;
      if (load[i]) begin
        ang_d = ANGLE_W'(lv);
      end else if (!freeze && en[i] && tick[i]) begin
        if (!dir[i]) begin
          if (sum > AMAX) begin
            ang_d  = ANGLE_W'(sum - MOD);
            wrap_d = 1'b1;
            lap_d  = lap_q + ONE;
          end else begin
            ang_d = ANGLE_W'(sum);
          end
        end else begin
          if (a < s) begin
            ang_d  = ANGLE_W'(a + MOD - s);
            wrap_d = 1'b1;
            lap_d  = lap_q - ONE;
          end else begin
            ang_d = ANGLE_W'(a - s);
          end
        end
      end
    end

    always_ff @(posedge clk1485) begin
      if (rst) begin
        ang_q  <= '0;
        lap_q  <= '0;
        wrap_q <= 1'b0;
      end else begin
        ang_q  <= ang_d;
        lap_q  <= lap_d;
        wrap_q <= wrap_d;
      end
    end

    assign angle[i*ANGLE_W +: ANGLE_W] = ang_q;
    assign lap_cnt[i*LAP_W +: LAP_W]   = lap_q;
    assign wrap[i]                     = wrap_q;
  end

endmodule

// File: tb/tb_orbit_angle_bank.sv
// Scoreboard bench for orbit_angle_bank: directed plan
// followed by a randomized soak against a reference model.
module tb_orbit_angle_bank;

  logic        clk1485;
  logic        rst;
  logic [2:0]  tick, en, dir, load;
  logic [11:0] step;
  logic        freeze;
  logic [26:0] load_val;
  logic [26:0] angle;
  logic [2:0]  wrap;
  logic [23:0] lap_cnt;

  orbit_angle_bank dut (
    .clk1485(clk1485), .rst(rst), .tick(tick), .en(en),
    .dir(dir), .step(step), .freeze(freeze), .load(load),
    .load_val(load_val), .angle(angle), .wrap(wrap),
    .lap_cnt(lap_cnt)
  );

  initial clk1485 = 1'b0;
  always #5 clk1485 = ~clk1485;

  typedef struct {
    logic [26:0] angle;
    logic [2:0]  wrap;
    logic [23:0] lap;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int m_ang[3];
  int m_lap[3];
  int m_wr[3];

  task automatic model_push();
    exp_t e;
    int s, lv, sum;
    for (int c = 0; c < 3; c++) begin
      s  = int'(step[c*4 +: 4]);
      if (s > 360) s = 360;
      lv = int'(load_val[c*9 +: 9]);
      if (lv > 359) lv = 359;
      if (rst) begin
        m_ang[c] = 0; m_lap[c] = 0; m_wr[c] = 0;
      end else if (load[c]) begin
        m_ang[c] = lv; m_wr[c] = 0;
      end else if (freeze || !en[c] || !tick[c]) begin
        m_wr[c] = 0;
      end else if (!dir[c]) begin
        sum = m_ang[c] + s;
        if (sum > 359) begin
          m_ang[c] = sum - 360; m_wr[c] = 1;
          m_lap[c] = (m_lap[c] + 1) % 256;
        end else begin
          m_ang[c] = sum; m_wr[c] = 0;
        end
      end else begin
        if (m_ang[c] < s) begin
          m_ang[c] = m_ang[c] + 360 - s; m_wr[c] = 1;
          m_lap[c] = (m_lap[c] + 255) % 256;
        end else begin
          m_ang[c] = m_ang[c] - s; m_wr[c] = 0;
        end
      end
      e.angle[c*9 +: 9] = 9'(m_ang[c]);
      e.wrap[c]         = (m_wr[c] != 0);
      e.lap[c*8 +: 8]   = 8'(m_lap[c]);
    end
    q.push_back(e);
  endtask

  task automatic cyc();
    model_push();
    @(posedge clk1485);
    @(negedge clk1485);
  endtask

  task automatic idle_in();
    rst = 0; tick = 0; load = 0; freeze = 0;
  endtask

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every edge produces one registered result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk1485);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_chk++;
        if (angle !== e.angle || wrap !== e.wrap ||
            lap_cnt !== e.lap) begin
          n_fail++;
          $display("FAIL scoreboard @%0t angle %h/%h wrap %b/%b lap %h/%h",
                   $time, angle, e.angle, wrap, e.wrap, lap_cnt, e.lap);
        end
        for (int c = 0; c < 3; c++) begin
          n_chk++;
          if (!(angle[c*9 +: 9] <= 9'd359)) begin
            n_fail++;
            $display("FAIL range ch%0d angle %0d max 359",
                     c, angle[c*9 +: 9]);
          end
        end
      end
    end
  end

  initial begin
    rst = 1; tick = 0; en = 3'b111; dir = 0; step = 0;
    freeze = 0; load = 0; load_val = 0;
    cyc();
    cyc();
    chk("reset_angle", int'(angle), 0);
    chk("reset_lap", int'(lap_cnt), 0);
    idle_in();

    // 1: full revolution on ch0
    step[3:0] = 4'd1;
    tick = 3'b001;
    for (int k = 0; k < 359; k++) cyc();
    chk("t1_angle359", int'(angle[8:0]), 359);
    chk("t1_nowrap", int'(wrap[0]), 0);
    cyc();
    chk("t1_angle0", int'(angle[8:0]), 0);
    chk("t1_wrap", int'(wrap[0]), 1);
    chk("t1_lap", int'(lap_cnt[7:0]), 1);
    chk("t1_others", int'(angle[26:9]), 0);
    tick = 0;
    cyc();
    chk("t1_wrap_drop", int'(wrap[0]), 0);

    // 2: ch1 forward then reverse across zero
    load = 3'b010; load_val[17:9] = 9'd355;
    cyc();
    load = 0; step[7:4] = 4'd7; tick = 3'b010;
    cyc();
    chk("t2_fwd_angle", int'(angle[17:9]), 2);
    chk("t2_fwd_wrap", int'(wrap[1]), 1);
    chk("t2_fwd_lap", int'(lap_cnt[15:8]), 1);
    dir[1] = 1'b1;
    cyc();
    chk("t2_rev_angle", int'(angle[17:9]), 355);
    chk("t2_rev_wrap", int'(wrap[1]), 1);
    chk("t2_rev_lap", int'(lap_cnt[15:8]), 0);

    // 3: ch2 reverse from 0, then clamped load
    dir[2] = 1'b1; step[11:8] = 4'd1; tick = 3'b100;
    cyc();
    chk("t3_angle", int'(angle[26:18]), 359);
    chk("t3_lap", int'(lap_cnt[23:16]), 255);
    tick = 0; load = 3'b100; load_val[26:18] = 9'd400;
    cyc();
    chk("t3_clamp", int'(angle[26:18]), 359);
    load = 0;

    // 4: freeze discards ticks, load still applies
    freeze = 1; tick = 3'b111;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("t4_frz_wrap", int'(wrap), 0);
    end
    chk("t4_frz_a0", int'(angle[8:0]), 0);
    chk("t4_frz_a1", int'(angle[17:9]), 355);
    chk("t4_frz_a2", int'(angle[26:18]), 359);
    load = 3'b001; load_val[8:0] = 9'd90;
    cyc();
    chk("t4_frz_load", int'(angle[8:0]), 90);
    load = 0; freeze = 0; tick = 0;

    // 5: load beats tick; disabled channel holds
    load = 3'b001; load_val[8:0] = 9'd10; step[3:0] = 4'd5;
    tick = 3'b011; en = 3'b101;
    cyc();
    chk("t5_load_angle", int'(angle[8:0]), 10);
    chk("t5_load_wrap", int'(wrap[0]), 0);
    chk("t5_en_hold", int'(angle[17:9]), 355);
    load = 0; en = 3'b111; tick = 0;

    // 6: reset beats tick, load and pending wrap
    dir[2] = 1'b0; tick = 3'b111; load = 3'b001;
    rst = 1;
    cyc();
    chk("t6_angle", int'(angle), 0);
    chk("t6_wrap", int'(wrap), 0);
    chk("t6_lap", int'(lap_cnt), 0);
    idle_in();

    for (int k = 0; k < 20000; k++) begin
      tick     = 3'($urandom);
      dir      = 3'($urandom);
      step     = 12'($urandom);
      en       = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      freeze   = ($urandom_range(0, 19) == 0);
      load     = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b000;
      load_val = 27'($urandom);
      rst      = ($urandom_range(0, 999) == 0);
      cyc();
    end
    idle_in();
    cyc();
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
